// File: rtl/mem_pkg.sv
`default_nettype none
// ==== mem_pkg: shared widths, FSM encoding and address-range helper for mem_arbiter (rev 1.0) ====
package mem_pkg;

    localparam int MEM_ADDR_W  = 27;
    localparam int WORD_ADDR_W = 30;
    localparam int DATA_W      = 32;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GRANT_IF = 3'd1,
        S_GRANT_D  = 3'd2,
        S_RESP_IF  = 3'd3,
        S_RESP_D   = 3'd4
    } arb_state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } grant_e;

    // Word addresses above the LPDDR2 window never reach the controller.
    function automatic logic addr_in_range(input logic [WORD_ADDR_W-1:0] addr);
        return addr[WORD_ADDR_W-1:MEM_ADDR_W] == '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_timeout_counter.sv
`default_nettype none
// ==== mem_timeout_counter: saturating wait counter, expired once LIMIT cycles have been counted (rev 1.0) ====
module mem_timeout_counter #(
    parameter int LIMIT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int              CNT_W   = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LIMIT_C);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ==== mem_arbiter: fetch/data requester arbiter in front of an LPDDR2 controller (rev 1.0) ====
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req,
    input  logic [WORD_ADDR_W-1:0] if_addr,
    output logic                   if_ack,
    output logic [DATA_W-1:0]      if_rdata,
    input  logic                   d_req,
    input  logic                   d_we,
    input  logic [WORD_ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0]      d_wdata,
    output logic                   d_ack,
    output logic [DATA_W-1:0]      d_rdata,
    output logic [MEM_ADDR_W-1:0]  lpddr2_address,
    output logic [DATA_W-1:0]      lpddr2_write_data,
    input  logic [DATA_W-1:0]      lpddr2_read_data,
    output logic                   lpddr2_rreq,
    output logic                   lpddr2_wreq,
    input  logic                   lpddr2_ack,
    output logic                   err,
    output logic                   busy
);

    arb_state_e             state_q, state_d;
    grant_e                 last_grant_q, last_grant_d;
    logic [WORD_ADDR_W-1:0] addr_q, addr_d;
    logic                   we_q, we_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic                   rreq_q, rreq_d;
    logic                   wreq_q, wreq_d;
    logic [DATA_W-1:0]      if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]      d_rdata_q, d_rdata_d;
    logic                   err_q, err_d;

    logic                   w_start;
    logic                   w_in_grant;
    logic                   w_ack_ok;
    logic                   w_expired;
    logic                   w_finish;
    logic [DATA_W-1:0]      w_result;

    assign w_start    = (state_q == S_IDLE) && (if_req || d_req);
    assign w_in_grant = (state_q == S_GRANT_IF) || (state_q == S_GRANT_D);
    // A controller ack only counts while our own request is on the bus.
    assign w_ack_ok   = lpddr2_ack && (rreq_q || wreq_q);

    mem_timeout_counter #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (w_start),
        .enable_i (w_in_grant),
        .expired_o(w_expired)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        rreq_d       = 1'b0;
        wreq_d       = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        err_d        = err_q;
        w_finish     = 1'b0;
        w_result     = '0;

        case (state_q)
            S_IDLE: begin
                if (if_req || d_req) begin
                    if (d_req && (!if_req || last_grant_q == GNT_IF)) begin
                        state_d      = S_GRANT_D;
                        last_grant_d = GNT_D;
                        addr_d       = d_addr;
                        we_d         = d_we;
                        wdata_d      = d_wdata;
                    end else begin
                        state_d      = S_GRANT_IF;
                        last_grant_d = GNT_IF;
                        addr_d       = if_addr;
                        we_d         = 1'b0;
                    end
                end
            end
            S_GRANT_IF, S_GRANT_D: begin
                // Ack is checked before expiry so a same-cycle ack completes cleanly.
                if (!addr_in_range(addr_q)) begin
                    w_finish = 1'b1;
                    err_d    = 1'b1;
                end else if (w_ack_ok) begin
                    w_finish = 1'b1;
                    w_result = lpddr2_read_data;
                end else if (w_expired) begin
                    w_finish = 1'b1;
                    err_d    = 1'b1;
                end else begin
                    rreq_d = !we_q;
                    wreq_d = we_q;
                end

                if (w_finish) begin
                    if (state_q == S_GRANT_IF) begin
                        state_d    = S_RESP_IF;
                        if_rdata_d = w_result;
                    end else begin
                        state_d = S_RESP_D;
                        if (!we_q) begin
                            d_rdata_d = w_result;
                        end
                    end
                end
            end
            S_RESP_IF, S_RESP_D: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= GNT_D;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            rreq_q       <= 1'b0;
            wreq_q       <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            rreq_q       <= rreq_d;
            wreq_q       <= wreq_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            err_q        <= err_d;
        end
    end

    assign if_ack            = (state_q == S_RESP_IF);
    assign d_ack             = (state_q == S_RESP_D);
    assign if_rdata          = if_rdata_q;
    assign d_rdata           = d_rdata_q;
    assign lpddr2_address    = addr_q[MEM_ADDR_W-1:0];
    assign lpddr2_write_data = wdata_q;
    assign lpddr2_rreq       = rreq_q;
    assign lpddr2_wreq       = wreq_q;
    assign err               = err_q;
    assign busy              = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ==== tb_mem_arbiter: directed vector table plus hand-written corner sequences for mem_arbiter (rev 1.0) ====
module tb_mem_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [29:0] if_addr, d_addr;
    logic [31:0] d_wdata;
    logic        if_ack, d_ack;
    logic [31:0] if_rdata, d_rdata;
    logic [26:0] lpddr2_address;
    logic [31:0] lpddr2_write_data, lpddr2_read_data;
    logic        lpddr2_rreq, lpddr2_wreq, lpddr2_ack;
    logic        err, busy;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .lpddr2_address(lpddr2_address), .lpddr2_write_data(lpddr2_write_data),
        .lpddr2_read_data(lpddr2_read_data), .lpddr2_rreq(lpddr2_rreq),
        .lpddr2_wreq(lpddr2_wreq), .lpddr2_ack(lpddr2_ack),
        .err(err), .busy(busy)
    );

    typedef struct {
        logic        is_d;
        logic        we;
        logic [29:0] addr;
        logic [31:0] wdata;
        int          dly;
        logic [31:0] rd;
        logic [26:0] exp_maddr;
        logic [31:0] exp_if;
        logic [31:0] exp_d;
    } vec_t;

    vec_t vecs[6];

    int n_tests = 0;
    int n_fail  = 0;

    // Controller model state
    bit          ctrl_en;
    int          ctrl_dly;
    logic [31:0] ctrl_data;
    int          req_cycles, last_req_len, overlap;
    bit          prev_req;
    bit          force_ack;
    logic [31:0] force_data;
    logic [59:0] log_q[$];
    int          ack_ord[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: step to the falling edge and play the LPDDR2 controller.
    task automatic cycle();
        @(negedge clk);
        lpddr2_ack = 1'b0;
        if (lpddr2_rreq && lpddr2_wreq) overlap++;
        if (lpddr2_rreq || lpddr2_wreq) begin
            if (!prev_req) log_q.push_back({lpddr2_wreq, lpddr2_address, lpddr2_write_data});
            req_cycles++;
            if (ctrl_en && req_cycles == ctrl_dly + 1) begin
                lpddr2_ack       = 1'b1;
                lpddr2_read_data = ctrl_data;
            end
        end else begin
            if (req_cycles != 0) last_req_len = req_cycles;
            req_cycles = 0;
        end
        prev_req = lpddr2_rreq || lpddr2_wreq;
        if (force_ack) begin
            lpddr2_ack       = 1'b1;
            lpddr2_read_data = force_data;
            force_ack        = 1'b0;
        end
    endtask

    task automatic do_txn(input logic is_d, input logic we, input logic [29:0] addr,
                          input logic [31:0] wdata, output int lat, output int nia, output int nda);
        bit done = 1'b0;
        lat = -1; nia = 0; nda = 0;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int i = 1; i <= 40; i++) begin
            cycle();
            if (if_ack) nia++;
            if (d_ack)  nda++;
            if (!done && (is_d ? d_ack : if_ack)) begin
                done = 1'b1; lat = i; if_req = 1'b0; d_req = 1'b0;
            end
            if (done && i >= lat + 3) break;
        end
        if_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic do_reset();
        if_req = 1'b0; d_req = 1'b0;
        rst = 1'b0;
        cycle(); cycle();
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, nia, nda, base, nf;
        logic [59:0] ent;

        vecs[0] = '{1'b0, 1'b0, 30'h10,       32'h0,        2, 32'h8C010004, 27'h10,       32'h8C010004, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 30'h20,       32'h0,        0, 32'h11223344, 27'h20,       32'h8C010004, 32'h11223344};
        vecs[2] = '{1'b1, 1'b1, 30'h7FFFFFF,  32'hCAFEF00D, 1, 32'hFFFFFFFF, 27'h7FFFFFF,  32'h8C010004, 32'h11223344};
        vecs[3] = '{1'b0, 1'b0, 30'h3,        32'h0,        5, 32'h00000013, 27'h3,        32'h00000013, 32'h11223344};
        vecs[4] = '{1'b1, 1'b0, 30'h123456,   32'h0,        3, 32'hA5A5A5A5, 27'h123456,   32'h00000013, 32'hA5A5A5A5};
        vecs[5] = '{1'b0, 1'b0, 30'h7000000,  32'h0,        6, 32'hFFFF0000, 27'h7000000,  32'hFFFF0000, 32'hA5A5A5A5};

        rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        lpddr2_ack = 1'b0; lpddr2_read_data = '0;
        ctrl_en = 1'b1; ctrl_dly = 0; ctrl_data = '0;
        req_cycles = 0; last_req_len = 0; overlap = 0; prev_req = 1'b0;
        force_ack = 1'b0; force_data = '0;

        cycle(); cycle();
        chk("reset_ctrl",   {busy, if_ack, d_ack, lpddr2_rreq, lpddr2_wreq, err}, 64'h0);
        chk("reset_rdata",  {if_rdata, d_rdata}, 64'h0);
        chk("reset_lpddr2", {lpddr2_address, lpddr2_write_data}, 64'h0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            ctrl_en = 1'b1; ctrl_dly = vecs[i].dly; ctrl_data = vecs[i].rd;
            base = log_q.size();
            do_txn(vecs[i].is_d, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, nia, nda);
            chk($sformatf("v%0d_latency", i), lat, 3 + vecs[i].dly);
            chk($sformatf("v%0d_acks", i), nia * 16 + nda, vecs[i].is_d ? 1 : 16);
            ent = (log_q.size() == base + 1) ? log_q[base] : 'x;
            chk($sformatf("v%0d_req", i), ent[59:32], {vecs[i].we, vecs[i].exp_maddr});
            if (vecs[i].we) chk($sformatf("v%0d_wdata", i), ent[31:0], vecs[i].wdata);
            chk($sformatf("v%0d_rdata", i), {if_rdata, d_rdata}, {vecs[i].exp_if, vecs[i].exp_d});
            chk($sformatf("v%0d_err_busy", i), {err, busy}, 2'b00);
        end

        // Ack lands on the very cycle the timeout expires: ack wins
        ctrl_dly = TO - 1; ctrl_data = 32'h1234;
        do_txn(1'b0, 1'b0, 30'h50, 32'h0, lat, nia, nda);
        chk("ackto_latency", lat, 3 + TO - 1);
        chk("ackto_req_len", last_req_len, TO);
        chk("ackto_rdata", if_rdata, 32'h1234);
        chk("ackto_err", err, 1'b0);

        // Simultaneous requests from reset: fetch first, then data beats a re-issued fetch
        do_reset();
        log_q.delete(); ack_ord.delete(); nf = 0;
        ctrl_en = 1'b1; ctrl_dly = 1; ctrl_data = 32'h8C000001;
        if_req = 1'b1; if_addr = 30'h10;
        d_req = 1'b1; d_we = 1'b1; d_addr = 30'h20; d_wdata = 32'hDEADBEEF;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (if_ack) begin
                ack_ord.push_back(0); nf++;
                if (nf == 1) if_addr = 30'h14; else if_req = 1'b0;
            end
            if (d_ack) begin
                ack_ord.push_back(1); d_req = 1'b0;
            end
            if (nf >= 2 && !d_req) break;
        end
        if_req = 1'b0; d_req = 1'b0;
        cycle(); cycle();
        chk("sim_nreq", log_q.size(), 3);
        if (log_q.size() >= 3) begin
            chk("sim_req0", log_q[0][59:32], {1'b0, 27'h10});
            chk("sim_req1", log_q[1], {1'b1, 27'h20, 32'hDEADBEEF});
            chk("sim_req2", log_q[2][59:32], {1'b0, 27'h14});
        end
        chk("sim_ack_order", (ack_ord.size() == 3) ? ack_ord[0] * 100 + ack_ord[1] * 10 + ack_ord[2] : -1, 10);
        chk("sim_rdata", {if_rdata, d_rdata}, {32'h8C000001, 32'h0});

        // Out-of-range addresses
        ctrl_dly = 0; ctrl_data = 32'h0BADC0DE;
        do_txn(1'b1, 1'b0, 30'h30, 32'h0, lat, nia, nda);
        chk("oor_pre_load", {err, d_rdata}, {1'b0, 32'h0BADC0DE});
        base = log_q.size();
        do_txn(1'b1, 1'b0, 30'h0800_0000, 32'h0, lat, nia, nda);
        chk("oor_d_noreq", log_q.size(), base);
        chk("oor_d_acks", nia * 16 + nda, 1);
        chk("oor_d_result", {err, d_rdata}, {1'b1, 32'h0});
        do_txn(1'b0, 1'b0, 30'h3800_0000, 32'h0, lat, nia, nda);
        chk("oor_if_noreq", log_q.size(), base);
        chk("oor_if_result", {nia, if_rdata, err}, {32'd1, 32'h0, 1'b1});

        // Timeout with no controller ack, then a late ack
        do_reset();
        chk("to_err_cleared", err, 1'b0);
        ctrl_en = 1'b1; ctrl_dly = 0; ctrl_data = 32'h77;
        do_txn(1'b0, 1'b0, 30'h44, 32'h0, lat, nia, nda);
        chk("to_pre_fetch", if_rdata, 32'h77);
        ctrl_en = 1'b0;
        do_txn(1'b0, 1'b0, 30'h40, 32'h0, lat, nia, nda);
        chk("to_latency", lat, TO + 2);
        chk("to_req_len", last_req_len, TO);
        chk("to_result", {nia, if_rdata, err}, {32'd1, 32'h0, 1'b1});
        force_ack = 1'b1; force_data = 32'h5555;
        nia = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (if_ack || d_ack) nia++;
        end
        chk("late_ack_ignored", {nia, if_rdata, busy}, {32'd0, 32'h0, 1'b0});

        // Reset asserted mid-store while wreq is high
        do_reset();
        ctrl_en = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 30'h60; d_wdata = 32'h12345678;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (lpddr2_wreq) break;
        end
        chk("rstmid_pre", {lpddr2_wreq, busy}, 2'b11);
        rst = 1'b0;
        #1;
        chk("rstmid_immediate", {lpddr2_wreq, lpddr2_rreq, busy}, 3'b000);
        d_req = 1'b0;
        cycle();
        rst = 1'b1;
        force_ack = 1'b1; force_data = 32'h9999;
        nda = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (d_ack || busy) nda++;
        end
        chk("rstmid_after", {nda, err, d_rdata}, {32'd0, 1'b0, 32'h0});

        chk("rreq_wreq_exclusive", overlap, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1023: max cycles awaiting lpddr2_ack before the access is abandoned.
REQ-002 Port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port rst  input  1  asynchronous, active-low reset.
REQ-004 Port if_req  input  1  fetch requester read request, held until if_ack.
REQ-005 Port if_addr  input  30  fetch word address (pc[31:2]).
REQ-006 Port if_ack  output  1  one-cycle pulse, if_rdata valid.
REQ-007 Port if_rdata  output  32  fetched instruction word.
REQ-008 Port d_req  input  1  data requester request, held until d_ack.
REQ-009 Port d_we  input  1  1 = store, 0 = load; sampled with d_req.
REQ-010 Port d_addr  input  30  data word address.
REQ-011 Port d_wdata  input  32  store data.
REQ-012 Port d_ack  output  1  one-cycle pulse, load data valid / store done.
REQ-013 Port d_rdata  output  32  load data.
REQ-014 Port lpddr2_address  output  27  word address to LPDDR2 controller.
REQ-015 Port lpddr2_write_data  output  32  store data to controller.
REQ-016 Port lpddr2_read_data  input  32  read data from controller.
REQ-017 Port lpddr2_rreq / lpddr2_wreq  output  1 each  read/write request, held high until lpddr2_ack.
REQ-018 Port lpddr2_ack  input  1  one-cycle completion pulse from controller.
REQ-019 Port err  output  1  sticky: timeout or out-of-range address occurred.
REQ-020 Port busy  output  1  high in any state other than IDLE.

Function
REQ-021 FSM states IDLE, GRANT_IF, GRANT_D, RESP_IF, RESP_D.
REQ-022 IDLE: sample requests; grant to GRANT_IF or GRANT_D per REQ-023; no request -> stay.
REQ-023 Arbitration: single requester wins; both pending -> the one not granted last (last_grant register, reset value = data, so fetch wins first).
REQ-024 On grant, address/we/wdata registered; lpddr2_address = addr[26:0]; rreq (or wreq for store) asserted from the cycle after grant until lpddr2_ack inclusive.
REQ-025 lpddr2_ack in GRANT_x: read data registered into x_rdata, go RESP_x; next cycle x_ack pulses one cycle, return IDLE.
REQ-026 Latency: request seen in IDLE at cycle N, controller ack at cycle M -> x_ack at M+1; minimum N+3.
REQ-027 Out-of-range: addr[29:27] nonzero -> no LPDDR2 request; go RESP_x directly, rdata = 0, err set.
REQ-028 Timeout: counter cleared on grant, increments in GRANT_x; reaching TIMEOUT_CYCLES without ack -> drop rreq/wreq, rdata = 0, err set, go RESP_x.
REQ-029 lpddr2_ack outside GRANT_x ignored; ack and timeout in same cycle -> ack wins, err unchanged.
REQ-030 Requester deasserting req mid-transaction does not abort; ack still issued.
REQ-031 if_rdata/d_rdata hold last value between acks; stores leave d_rdata unchanged.
REQ-032 Never more than one LPDDR2 request outstanding; rreq and wreq never high together.

Reset
REQ-033 rst low: state IDLE, all acks/reqs/err/busy 0, rdata 0, address/write_data 0, counter 0, last_grant = data; effective immediately, mid-transaction included; pending controller ack after release ignored.

Structure
REQ-034 State enum, MEM_ADDR_W = 27, WORD_ADDR_W = 30 live in shared package mem_pkg.
REQ-035 Single sub-module mem_timeout_counter (clear, enable, expired) instantiated once.

Verification
REQ-036 if_req only, addr 0x10, ack 2 cycles after rreq with 0x8C010004 -> lpddr2_address 0x10, if_rdata 0x8C010004, one if_ack.
REQ-037 if_req and d_req (store 0x20, data 0xDEADBEEF) same cycle from reset -> fetch served first, then wreq with address 0x20, write_data 0xDEADBEEF; next simultaneous pair served data-first.
REQ-038 d_req load addr 0x0800_0000 (bit 27 set) -> no rreq, d_ack with d_rdata 0, err = 1.
REQ-039 TIMEOUT_CYCLES = 8, no ack -> rreq drops after 8 cycles, if_ack with 0, err = 1; late ack ignored.
REQ-040 rst low while GRANT_D with wreq high -> wreq, busy 0 same cycle; after release, IDLE, no d_ack.
REQ-041 Ack on the exact timeout cycle with data 0x1234 -> rdata 0x1234, err remains 0.
